// File: rtl/painterengine_gpu_pkg.sv
// Shared definitions for the painterengine GPU pixel blocks.
// Optional feature macro: PAINTERENGINE_GPU_UNPREMUL_ROUND_EN
//   defined   -> unpremultiply dividend carries a +pa/2 bias (round to nearest)
//   undefined -> plain p*255 dividend (truncating quotient)
package painterengine_gpu_pkg;

  localparam int PE_CH_W      = 8;
  localparam int PE_DIV_STEPS = 8;
  localparam logic [7:0] PE_CH_MAX = 8'd255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_DONE = 2'd2
  } pe_state_t;

  // Dividend for one channel: p*255, optionally biased by pa/2 for rounding.
  // Max value 255*255 + 127 = 65152, so 16 bits never overflow.
  function automatic logic [15:0] pe_dividend(input logic [7:0] p, input logic [7:0] pa);
    logic [15:0] d;
    d = {p, 8'd0} - {8'd0, p};
`ifdef PAINTERENGINE_GPU_UNPREMUL_ROUND_EN
    d = d + {9'd0, pa[7:1]};
`else
    d = d + 16'd0 * {8'd0, pa};
`endif
    return d;
  endfunction

endpackage

// File: rtl/painterengine_gpu_divstep.sv
// One combinational restoring-division step: shift in the next dividend bit,
// subtract the divisor when it fits and emit the matching quotient bit.
module painterengine_gpu_divstep (
  input  logic [8:0] rem,
  input  logic [7:0] pa,
  input  logic       din,
  output logic [8:0] rem_next,
  output logic       qbit
);

  // Keep the full 9-bit remainder in the shift so an out-of-range remainder
  // (only possible on clamped channels, whose result is discarded) cannot wrap.
  logic [9:0] shifted;
  logic [9:0] diff;

  assign shifted  = {rem, din};
  assign diff     = shifted - {2'b00, pa};
  assign qbit     = (shifted >= {2'b00, pa});
  assign rem_next = qbit ? diff[8:0] : shifted[8:0];

endmodule

// File: rtl/painterengine_gpu_unpremultiply.sv
// Premultiplied ARGB8888 -> straight alpha. Three channels share one 8-step
// restoring divider schedule; fixed 8-cycle latency, valid/ready on both sides.
// Optional feature macro: PAINTERENGINE_GPU_UNPREMUL_ROUND_EN (rounded quotient,
// applied through the package dividend helper).
module painterengine_gpu_unpremultiply (
  input  logic       i_wire_clock,
  input  logic       i_wire_resetn,
  input  logic       i_wire_valid,
  output logic       o_wire_ready,
  input  logic [7:0] pa,
  input  logic [7:0] pr,
  input  logic [7:0] pg,
  input  logic [7:0] pb,
  output logic       o_wire_valid,
  input  logic       i_wire_ready,
  output logic [7:0] a,
  output logic [7:0] r,
  output logic [7:0] g,
  output logic [7:0] b
);

  import painterengine_gpu_pkg::*;

  localparam logic [2:0] CNT_LAST = 3'(PE_DIV_STEPS - 1);

  pe_state_t   state_reg, state_next;
  logic [2:0]  cnt_reg;
  logic [7:0]  pa_reg;
  logic [7:0]  a_reg;
  logic        accept;
  logic        last_step;
  logic [7:0]  p_in    [3];
  logic [7:0]  ch_out  [3];

  assign accept    = (state_reg == ST_IDLE) && i_wire_valid;
  assign last_step = (state_reg == ST_DIV) && (cnt_reg == 3'd0);

  assign p_in[0] = pr;
  assign p_in[1] = pg;
  assign p_in[2] = pb;

  // State register.
  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) state_reg <= ST_IDLE;
    else                state_reg <= state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next   = state_reg;
    o_wire_ready = 1'b0;
    o_wire_valid = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        o_wire_ready = 1'b1;
        if (i_wire_valid) state_next = ST_DIV;
      end
      ST_DIV: begin
        if (cnt_reg == 3'd0) state_next = ST_DONE;
      end
      ST_DONE: begin
        o_wire_valid = 1'b1;
        if (i_wire_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Step counter, latched alpha and the alpha output.
  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      cnt_reg <= 3'd0;
      pa_reg  <= 8'd0;
      a_reg   <= 8'd0;
    end else if (accept) begin
      cnt_reg <= CNT_LAST;
      pa_reg  <= pa;
    end else if (state_reg == ST_DIV) begin
      cnt_reg <= cnt_reg - 3'd1;
      if (cnt_reg == 3'd0) a_reg <= pa_reg;
    end
  end

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_ch
      logic [15:0] d_w;
      logic [7:0]  dlo_reg;
      logic [8:0]  rem_reg;
      logic [7:0]  q_reg;
      logic        clamp_reg;
      logic [7:0]  out_reg;
      logic [8:0]  rem_step;
      logic        qbit_step;
      logic [7:0]  q_final;

      assign d_w     = pe_dividend(p_in[gi], pa);
      assign q_final = {q_reg[6:0], qbit_step};

      painterengine_gpu_divstep u_step (
        .rem      (rem_reg),
        .pa       (pa_reg),
        .din      (dlo_reg[cnt_reg]),
        .rem_next (rem_step),
        .qbit     (qbit_step)
      );

      // Per-channel divider state; result resolved on the final step so it is
      // already stable when DONE is entered.
      always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
          dlo_reg   <= 8'd0;
          rem_reg   <= 9'd0;
          q_reg     <= 8'd0;
          clamp_reg <= 1'b0;
          out_reg   <= 8'd0;
        end else if (accept) begin
          dlo_reg   <= d_w[7:0];
          rem_reg   <= {1'b0, d_w[15:8]};
          q_reg     <= 8'd0;
          clamp_reg <= (p_in[gi] >= pa);
        end else if (state_reg == ST_DIV) begin
          rem_reg <= rem_step;
          q_reg   <= q_final;
          if (last_step) begin
            if (pa_reg == 8'd0)  out_reg <= 8'd0;
            else if (clamp_reg)  out_reg <= PE_CH_MAX;
            else                 out_reg <= q_final;
          end
        end
      end

      assign ch_out[gi] = out_reg;
    end
  endgenerate

  assign a = a_reg;
  assign r = ch_out[0];
  assign g = ch_out[1];
  assign b = ch_out[2];

endmodule

// File: tb/tb_painterengine_gpu_unpremultiply.sv
// Directed bench for painterengine_gpu_unpremultiply. Expected values are
// hand-computed for both builds (PAINTERENGINE_GPU_UNPREMUL_ROUND_EN on/off).
module tb_painterengine_gpu_unpremultiply;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       out_ready_dut;
  logic [7:0] pa, pr, pg, pb;
  logic       out_valid;
  logic       in_ready;
  logic [7:0] a, r, g, b;

  int total  = 0;
  int passed = 0;
  int cyc    = 0;
  int acc_cyc;
  int prev_acc;

  painterengine_gpu_unpremultiply dut (
    .i_wire_clock  (clk),
    .i_wire_resetn (rst_n),
    .i_wire_valid  (in_valid),
    .o_wire_ready  (out_ready_dut),
    .pa            (pa),
    .pr            (pr),
    .pg            (pg),
    .pb            (pb),
    .o_wire_valid  (out_valid),
    .i_wire_ready  (in_ready),
    .a             (a),
    .r             (r),
    .g             (g),
    .b             (b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a pixel and let it be accepted; leaves i_wire_valid low afterwards.
  task automatic accept_px(input string tag, input logic [7:0] a_i, r_i, g_i, b_i);
    int n;
    pa = a_i; pr = r_i; pg = g_i; pb = b_i;
    in_valid = 1'b1;
    n = 0;
    while (!out_ready_dut && n < 30) begin
      tick();
      n++;
    end
    check({tag, "_ready_before"}, out_ready_dut, 1);
    tick();
    acc_cyc  = cyc;
    in_valid = 1'b0;
    check({tag, "_busy"}, out_ready_dut, 0);
  endtask

  // Count edges from acceptance until the result is presented.
  task automatic wait_result(input string tag);
    int lat;
    lat = 0;
    while (!out_valid && lat < 30) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, 8);
  endtask

  task automatic expect_out(input string tag, input logic [7:0] ea, er, eg, eb);
    $display("txn %s: a=%0d r=%0d g=%0d b=%0d (want %0d/%0d/%0d/%0d)", tag, a, r, g, b, ea, er, eg, eb);
    check({tag, "_a"}, a, ea);
    check({tag, "_r"}, r, er);
    check({tag, "_g"}, g, eg);
    check({tag, "_b"}, b, eb);
  endtask

  task automatic handshake(input string tag);
    in_ready = 1'b1;
    tick();
    in_ready = 1'b0;
    check({tag, "_valid_drop"}, out_valid, 0);
    check({tag, "_ready_back"}, out_ready_dut, 1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_ready = 1'b0;
    pa = 8'd0; pr = 8'd0; pg = 8'd0; pb = 8'd0;
    #12;
    check("rst_ready", out_ready_dut, 1);
    check("rst_valid", out_valid, 0);
    check("rst_a", a, 0);
    check("rst_r", r, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    // pa=128, 64/0/127
    accept_px("t1", 8'd128, 8'd64, 8'd0, 8'd127);
    wait_result("t1");
`ifdef PAINTERENGINE_GPU_UNPREMUL_ROUND_EN
    expect_out("t1", 8'd128, 8'd128, 8'd0, 8'd253);
`else
    expect_out("t1", 8'd128, 8'd127, 8'd0, 8'd253);
`endif
    handshake("t1");

    // zero alpha: everything zero, latency unchanged
    accept_px("t0", 8'd0, 8'd10, 8'd20, 8'd30);
    wait_result("t0");
    expect_out("t0", 8'd0, 8'd0, 8'd0, 8'd0);
    handshake("t0");

    // opaque: identity, b via clamp
    accept_px("t2", 8'd255, 8'd200, 8'd1, 8'd255);
    wait_result("t2");
    expect_out("t2", 8'd255, 8'd200, 8'd1, 8'd255);
    handshake("t2");

    // pa=100, 150/100/50: two clamps, one division; then hold in DONE
    accept_px("t3", 8'd100, 8'd150, 8'd100, 8'd50);
    prev_acc = acc_cyc;
    wait_result("t3");
    for (int i = 0; i < 5; i++) begin
      pa = 8'(i * 37 + 3); pr = 8'(i * 11); pg = 8'd255; pb = 8'(i);
      in_valid = 1'b1;
      tick();
    end
    check("hold_ready_low", out_ready_dut, 0);
    check("hold_valid_high", out_valid, 1);
`ifdef PAINTERENGINE_GPU_UNPREMUL_ROUND_EN
    expect_out("t3_hold", 8'd100, 8'd255, 8'd255, 8'd128);
`else
    expect_out("t3_hold", 8'd100, 8'd255, 8'd255, 8'd127);
`endif
    // Release with a new pixel already waiting: accepted one cycle after.
    pa = 8'd255; pr = 8'd9; pg = 8'd8; pb = 8'd7;
    in_valid = 1'b1;
    handshake("t3");
    tick();
    acc_cyc  = cyc;
    in_valid = 1'b0;
    check("b2b_accepted", out_ready_dut, 0);
    check("b2b_spacing_ge10", ((acc_cyc - prev_acc) >= 10), 1);
    wait_result("t5");
    expect_out("t5", 8'd255, 8'd9, 8'd8, 8'd7);
    handshake("t5");

    // Reset during DIV cycle 4 aborts and clears outputs immediately.
    accept_px("t6", 8'd100, 8'd150, 8'd100, 8'd50);
    for (int i = 0; i < 4; i++) tick();
    check("mid_busy", out_ready_dut, 0);
    #3 rst_n = 1'b0;
    #1;
    check("abort_valid", out_valid, 0);
    check("abort_ready", out_ready_dut, 1);
    expect_out("abort", 8'd0, 8'd0, 8'd0, 8'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    accept_px("t7", 8'd255, 8'd42, 8'd0, 8'd0);
    wait_result("t7");
    expect_out("t7", 8'd255, 8'd42, 8'd0, 8'd0);
    handshake("t7");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Absolute safety net so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
